ones_cnt_fsm_dp: RTL and testbench

Parametrised ones-counter: a shift register R1, counter R2 and carry flip-flop E, now with an integrated control FSM and a start/done handshake. The previous generation needed external strobes for load, increment and shift; this block sequences them itself and supports any data width. It sits behind a simple requester that presents an operand and waits for the popcount result.

---
 rtl/ones_cnt_fsm_dp_pkg.sv | 23 ++
 rtl/ones_cnt_fsm_dp_if.sv | 42 ++++
 rtl/ones_cnt_fsm_dp_datapath.sv | 67 ++++++
 rtl/ones_cnt_fsm_dp.sv | 95 +++++++++
 tb/tb_ones_cnt_fsm_dp.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ones_cnt_fsm_dp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ones_cnt_pkg
//  Purpose  : Shared types and helpers for the ones-counter FSM + datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package ones_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TEST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 8;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : ones_cnt_pkg
`default_nettype wire

// File: rtl/ones_cnt_fsm_dp_if.sv
`default_nettype none
// ============================================================================
//  Module   : ones_cnt_fsm_dp_if
//  Purpose  : Start/done request bus between a requester and the ones-counter.
//             Carries the parity bit only when ONES_CNT_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface ones_cnt_fsm_dp_if #(
    parameter int DATA_W = 8
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              zero;
    logic              e;
`ifdef ONES_CNT_PARITY_EN
    logic              parity;
`endif

`ifdef ONES_CNT_PARITY_EN
    modport master (output start, output data_in,
                    input ready, input busy, input done, input count,
                    input zero, input e, input parity);
    modport slave  (input start, input data_in,
                    output ready, output busy, output done, output count,
                    output zero, output e, output parity);
`else
    modport master (output start, output data_in,
                    input ready, input busy, input done, input count,
                    input zero, input e);
    modport slave  (input start, input data_in,
                    output ready, output busy, output done, output count,
                    output zero, output e);
`endif

endinterface : ones_cnt_fsm_dp_if
`default_nettype wire

// File: rtl/ones_cnt_fsm_dp_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : ones_cnt_datapath
//  Purpose  : Shift register R1, counter R2 and carry flop E, sequenced by
//             load / shift / incr strobes from the controlling FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module ones_cnt_datapath
    import ones_cnt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load,
    input  logic              shift,
    input  logic              incr,
    input  logic [DATA_W-1:0] data_in,
    output logic [CNT_W-1:0]  count,
    output logic              zero,
    output logic              e
);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [DATA_W-1:0] r1_q, r1_d;
    logic [CNT_W-1:0]  r2_q, r2_d;
    logic              e_q,  e_d;

    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        e_d  = e_q;
        if (load) begin
            r1_d = data_in;
            r2_d = '0;
            e_d  = 1'b0;
        end else begin
            if (shift) begin
                e_d  = r1_q[DATA_W-1];
                r1_d = {r1_q[DATA_W-2:0], 1'b0};
            end
            // R2 can never exceed DATA_W, which CNT_W always holds
            if (incr) begin
                r2_d = r2_q + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r1_q <= '0;
            r2_q <= '0;
            e_q  <= 1'b0;
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
            e_q  <= e_d;
        end
    end

    assign count = r2_q;
    assign zero  = (r1_q == '0);
    assign e     = e_q;

endmodule : ones_cnt_datapath
`default_nettype wire

// File: rtl/ones_cnt_fsm_dp.sv
`default_nettype none
// ============================================================================
//  Module   : ones_cnt_fsm_dp
//  Purpose  : Self-sequencing popcount engine with start/done handshake.
//             Optional parity output enabled by ONES_CNT_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ones_cnt_fsm_dp
    import ones_cnt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = cnt_w(DATA_W)
) (
    input  logic                clk,
    input  logic                rst_b,
    ones_cnt_fsm_dp_if.slave    bus
);
    state_t state_q, state_d;

    logic w_load;
    logic w_shift;
    logic w_incr;
    logic w_zero;
    logic w_e;
    logic [CNT_W-1:0] w_count;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_incr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    w_load  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Stop as soon as no set bits remain, not after DATA_W shifts
                if (w_zero) begin
                    state_d = DONE;
                end else begin
                    w_shift = 1'b1;
                    state_d = TEST;
                end
            end
            TEST: begin
                w_incr  = w_e;
                state_d = SHIFT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ones_cnt_datapath #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_datapath (
        .clk     (clk),
        .rst_b   (rst_b),
        .load    (w_load),
        .shift   (w_shift),
        .incr    (w_incr),
        .data_in (bus.data_in),
        .count   (w_count),
        .zero    (w_zero),
        .e       (w_e)
    );

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q == SHIFT) || (state_q == TEST);
    assign bus.done  = (state_q == DONE);
    assign bus.count = w_count;
    assign bus.zero  = w_zero;
    assign bus.e     = w_e;
`ifdef ONES_CNT_PARITY_EN
    assign bus.parity = w_count[0];
`endif

endmodule : ones_cnt_fsm_dp
`default_nettype wire

// File: tb/tb_ones_cnt_fsm_dp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ones_cnt_fsm_dp
//  Purpose  : Self-checking bench for 4-bit and 8-bit ones-counter instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ones_cnt_fsm_dp;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    ones_cnt_fsm_dp_if #(.DATA_W(4)) b4 ();
    ones_cnt_fsm_dp_if #(.DATA_W(8)) b8 ();

    ones_cnt_fsm_dp #(.DATA_W(4)) dut4 (.clk(clk), .rst_b(rst_b), .bus(b4));
    ones_cnt_fsm_dp #(.DATA_W(8)) dut8 (.clk(clk), .rst_b(rst_b), .bus(b8));

    int checks = 0;
    int errors = 0;

    // Observations captured by the op tasks
    int r_lat, r_ndone, r_cnt;
    logic r_rdy, r_zero, r_busy, r_par;

    function automatic int ref_popcount(input logic [31:0] d, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) n += d[i] ? 1 : 0;
        return n;
    endfunction

    function automatic int ref_latency(input logic [31:0] d, input int w);
        for (int i = 0; i < w; i++)
            if (d[i]) return 2 * (w - i) + 1;
        return 1;
    endfunction

    task automatic op4(input logic [3:0] d);
        b4.start = 1'b1; b4.data_in = d;
        @(posedge clk); @(negedge clk);
        b4.start = 1'b0; b4.data_in = 4'($urandom);
        r_rdy = b4.ready; r_lat = -1; r_ndone = 0;
        r_cnt = -1; r_zero = 1'bx; r_busy = 1'bx; r_par = 1'bx;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); @(negedge clk);
            if (b4.done) begin
                r_ndone++;
                if (r_lat < 0) begin
                    r_lat = n; r_cnt = int'(b4.count);
                    r_zero = b4.zero; r_busy = b4.busy;
`ifdef ONES_CNT_PARITY_EN
                    r_par = b4.parity;
`endif
                end
            end
        end
    endtask

    task automatic op8(input logic [7:0] d);
        b8.start = 1'b1; b8.data_in = d;
        @(posedge clk); @(negedge clk);
        b8.start = 1'b0; b8.data_in = 8'($urandom);
        r_rdy = b8.ready; r_lat = -1; r_ndone = 0;
        r_cnt = -1; r_zero = 1'bx; r_busy = 1'bx; r_par = 1'bx;
        for (int n = 1; n <= 26; n++) begin
            @(posedge clk); @(negedge clk);
            if (b8.done) begin
                r_ndone++;
                if (r_lat < 0) begin
                    r_lat = n; r_cnt = int'(b8.count);
                    r_zero = b8.zero; r_busy = b8.busy;
`ifdef ONES_CNT_PARITY_EN
                    r_par = b8.parity;
`endif
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0; b4.start = 1'b1; b8.start = 1'b1;
        b4.data_in = 4'hF; b8.data_in = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        b4.start = 1'b0; b8.start = 1'b0;
        checks++;
        if ({b4.ready, b4.busy, b4.done, b4.zero, b4.e} !== 5'b10010) begin
            errors++; $display("FAIL reset4_status: got %b expected 10010",
                               {b4.ready, b4.busy, b4.done, b4.zero, b4.e});
        end
        checks++;
        if ({b8.ready, b8.busy, b8.done, b8.zero, b8.e} !== 5'b10010) begin
            errors++; $display("FAIL reset8_status: got %b expected 10010",
                               {b8.ready, b8.busy, b8.done, b8.zero, b8.e});
        end
        checks++;
        if (b4.count !== 3'd0 || b8.count !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d/%0d expected 0/0", b4.count, b8.count);
        end
`ifdef ONES_CNT_PARITY_EN
        checks++;
        if (b4.parity !== 1'b0 || b8.parity !== 1'b0) begin
            errors++; $display("FAIL reset_parity: got %b/%b expected 0/0", b4.parity, b8.parity);
        end
`endif
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic4();
        op4(4'b1010);
        checks++;
        if (r_rdy !== 1'b0) begin
            errors++; $display("FAIL basic4_ready_drop: got %b expected 0", r_rdy);
        end
        checks++;
        if (r_lat != 7) begin
            errors++; $display("FAIL basic4_latency: got %0d expected 7", r_lat);
        end
        checks++;
        if (r_cnt != 2 || r_zero !== 1'b1 || r_busy !== 1'b0) begin
            errors++; $display("FAIL basic4_result: got cnt=%0d zero=%b busy=%b expected 2 1 0",
                               r_cnt, r_zero, r_busy);
        end
        checks++;
        if (r_ndone != 1) begin
            errors++; $display("FAIL basic4_done_pulses: got %0d expected 1", r_ndone);
        end
    endtask

    task automatic test_zero8();
        op8(8'h00);
        checks++;
        if (r_lat != 1 || r_cnt != 0 || r_ndone != 1) begin
            errors++; $display("FAIL zero8: got lat=%0d cnt=%0d pulses=%0d expected 1 0 1",
                               r_lat, r_cnt, r_ndone);
        end
    endtask

    task automatic test_full8();
        op8(8'hFF);
        checks++;
        if (r_lat != 17 || r_cnt != 8) begin
            errors++; $display("FAIL full8: got lat=%0d cnt=%0d expected 17 8", r_lat, r_cnt);
        end
`ifdef ONES_CNT_PARITY_EN
        checks++;
        if (r_par !== 1'b0) begin
            errors++; $display("FAIL full8_parity: got %b expected 0", r_par);
        end
`endif
    endtask

    task automatic test_ignore_start8();
        int lat = -1, cnt = -1, pulses = 0;
        b8.start = 1'b1; b8.data_in = 8'h81;
        @(posedge clk); @(negedge clk);
        b8.start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) begin b8.start = 1'b1; b8.data_in = 8'hFF; end
            else b8.start = 1'b0;
            @(posedge clk); @(negedge clk);
            if (b8.done) begin
                pulses++;
                if (lat < 0) begin lat = n; cnt = int'(b8.count); end
            end
        end
        checks++;
        if (pulses != 1 || lat != 17 || cnt != 2) begin
            errors++; $display("FAIL ignore_start8: got pulses=%0d lat=%0d cnt=%0d expected 1 17 2",
                               pulses, lat, cnt);
        end
        checks++;
        if (b8.count !== 4'd2 || b8.ready !== 1'b1) begin
            errors++; $display("FAIL ignore_start8_hold: got cnt=%0d ready=%b expected 2 1",
                               b8.count, b8.ready);
        end
    endtask

    task automatic test_reset_mid4();
        int pulses = 0;
        b4.start = 1'b1; b4.data_in = 4'b1111;
        @(posedge clk); @(negedge clk);
        b4.start = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (b4.busy !== 1'b1 || b4.e !== 1'b1) begin
            errors++; $display("FAIL reset_mid4_pre: got busy=%b e=%b expected 1 1", b4.busy, b4.e);
        end
        rst_b = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_b = 1'b1;
        checks++;
        if (b4.ready !== 1'b1 || b4.busy !== 1'b0 || b4.count !== 3'd0 || b4.done !== 1'b0) begin
            errors++; $display("FAIL reset_mid4_state: got ready=%b busy=%b cnt=%0d done=%b expected 1 0 0 0",
                               b4.ready, b4.busy, b4.count, b4.done);
        end
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); @(negedge clk);
            if (b4.done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL reset_mid4_no_done: got %0d pulses expected 0", pulses);
        end
        op4(4'b0110);
        checks++;
        if (r_cnt != 2 || r_lat != 7) begin
            errors++; $display("FAIL reset_mid4_after: got cnt=%0d lat=%0d expected 2 7", r_cnt, r_lat);
        end
    endtask

    task automatic test_back_to_back4();
        int rq[$];
        int dq[$];
        int bad_cnt = 0;
        b4.start = 1'b1; b4.data_in = 4'b0001;
        if (b4.ready) rq.push_back(0);
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); @(negedge clk);
            if (b4.ready) rq.push_back(c);
            if (b4.done) begin
                dq.push_back(c);
                if (b4.count !== 3'd1) bad_cnt++;
            end
        end
        b4.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dq.size() != 4 || rq.size() != 5) begin
            errors++; $display("FAIL b2b_counts: got done=%0d ready=%0d expected 4 5", dq.size(), rq.size());
        end
        for (int i = 0; i < dq.size(); i++) begin
            if (i + 1 < rq.size()) begin
                checks++;
                if (dq[i] != rq[i] + 10 || rq[i+1] != rq[i] + 11) begin
                    errors++; $display("FAIL b2b_timing[%0d]: got ready=%0d done=%0d next_ready=%0d expected done=ready+10 next=ready+11",
                                       i, rq[i], dq[i], rq[i+1]);
                end
            end
        end
        checks++;
        if (bad_cnt != 0) begin
            errors++; $display("FAIL b2b_count_value: got %0d wrong counts expected 0", bad_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] d8;
        logic [3:0] d4;
        for (int i = 0; i < 20; i++) begin
            d8 = 8'($urandom);
            op8(d8);
            checks++;
            if (r_cnt != ref_popcount(32'(d8), 8) || r_lat != ref_latency(32'(d8), 8) || r_ndone != 1) begin
                errors++; $display("FAIL rand8 d=%h: got cnt=%0d lat=%0d pulses=%0d expected %0d %0d 1",
                                   d8, r_cnt, r_lat, r_ndone, ref_popcount(32'(d8), 8), ref_latency(32'(d8), 8));
            end
`ifdef ONES_CNT_PARITY_EN
            checks++;
            if (r_par !== 1'(ref_popcount(32'(d8), 8) % 2)) begin
                errors++; $display("FAIL rand8_parity d=%h: got %b expected %0d",
                                   d8, r_par, ref_popcount(32'(d8), 8) % 2);
            end
`endif
        end
        for (int i = 0; i < 10; i++) begin
            d4 = 4'($urandom);
            op4(d4);
            checks++;
            if (r_cnt != ref_popcount(32'(d4), 4) || r_lat != ref_latency(32'(d4), 4) || r_ndone != 1) begin
                errors++; $display("FAIL rand4 d=%h: got cnt=%0d lat=%0d pulses=%0d expected %0d %0d 1",
                                   d4, r_cnt, r_lat, r_ndone, ref_popcount(32'(d4), 4), ref_latency(32'(d4), 4));
            end
        end
    endtask

    initial begin
        b4.start = 1'b0; b4.data_in = '0;
        b8.start = 1'b0; b8.data_in = '0;
        @(negedge clk);
        test_reset();
        test_basic4();
        test_zero8();
        test_full8();
        test_ignore_start8();
        test_reset_mid4();
        test_back_to_back4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ones_cnt_fsm_dp
`default_nettype wire
